// File: rtl/jtag_tap_sampled.sv
// JTAG TAP target that runs entirely on wb_clk_i. TCK/TMS/TDI are oversampled,
// and the TAP controller, IR, IDCODE and BYPASS logic advance on detected TCK edges.
module jtag_tap_sampled #(
  parameter logic [31:0] IDCODE_VALUE = 32'h14951185,
  parameter int unsigned IR_LENGTH    = 4
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic tck_pad_i,
  input  logic tms_pad_i,
  input  logic tdi_pad_i,
  output logic tdo_pad_o,
  input  logic debug_tdo_i,
  output logic debug_select_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic tdi_o
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;

  localparam logic [IR_LENGTH-1:0] INSTR_IDCODE = IR_LENGTH'(4'h2);
  localparam logic [IR_LENGTH-1:0] INSTR_DEBUG  = IR_LENGTH'(4'h8);
  localparam logic [IR_LENGTH-1:0] IR_CAPTURE   = IR_LENGTH'(4'b0101);

  logic tck_s1_q, tck_s2_q, tck_d_q;
  logic tms_s1_q, tms_s2_q;
  logic tdi_s1_q, tdi_s2_q;
  logic tck_rise, tck_fall;

  tap_state_e state_q, state_d;

  logic [IR_LENGTH-1:0] ir_q, ir_d;
  logic [IR_LENGTH-1:0] ir_shift_q, ir_shift_d;
  logic [31:0]          idcode_sr_q, idcode_sr_d;
  logic                 bypass_q, bypass_d;
  logic                 tdo_q, tdo_d;
  logic                 debug_select_q, debug_select_d;
  logic                 capture_dr_q, capture_dr_d;
  logic                 shift_dr_q, shift_dr_d;
  logic                 update_dr_q, update_dr_d;
  logic                 tdi_o_q, tdi_o_d;
  logic                 is_debug, is_idcode;

  // TMS/TDI share the TCK synchronizer depth so they line up with the detected edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tck_s1_q <= 1'b0;
      tck_s2_q <= 1'b0;
      tck_d_q  <= 1'b0;
      tms_s1_q <= 1'b0;
      tms_s2_q <= 1'b0;
      tdi_s1_q <= 1'b0;
      tdi_s2_q <= 1'b0;
    end else begin
      tck_s1_q <= tck_pad_i;
      tck_s2_q <= tck_s1_q;
      tck_d_q  <= tck_s2_q;
      tms_s1_q <= tms_pad_i;
      tms_s2_q <= tms_s1_q;
      tdi_s1_q <= tdi_pad_i;
      tdi_s2_q <= tdi_s1_q;
    end
  end

  assign tck_rise = tck_s2_q & ~tck_d_q;
  assign tck_fall = ~tck_s2_q & tck_d_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      unique case (state_q)
        TLR:      state_d = tms_s2_q ? TLR    : RTI;
        RTI:      state_d = tms_s2_q ? SEL_DR : RTI;
        SEL_DR:   state_d = tms_s2_q ? SEL_IR : CAP_DR;
        CAP_DR:   state_d = tms_s2_q ? EX1_DR : SH_DR;
        SH_DR:    state_d = tms_s2_q ? EX1_DR : SH_DR;
        EX1_DR:   state_d = tms_s2_q ? UPD_DR : PAUSE_DR;
        PAUSE_DR: state_d = tms_s2_q ? EX2_DR : PAUSE_DR;
        EX2_DR:   state_d = tms_s2_q ? UPD_DR : SH_DR;
        UPD_DR:   state_d = tms_s2_q ? SEL_DR : RTI;
        SEL_IR:   state_d = tms_s2_q ? TLR    : CAP_IR;
        CAP_IR:   state_d = tms_s2_q ? EX1_IR : SH_IR;
        SH_IR:    state_d = tms_s2_q ? EX1_IR : SH_IR;
        EX1_IR:   state_d = tms_s2_q ? UPD_IR : PAUSE_IR;
        PAUSE_IR: state_d = tms_s2_q ? EX2_IR : PAUSE_IR;
        EX2_IR:   state_d = tms_s2_q ? UPD_IR : SH_IR;
        UPD_IR:   state_d = tms_s2_q ? SEL_DR : RTI;
        default:  state_d = TLR;
      endcase
    end
  end

  assign is_debug  = (ir_q == INSTR_DEBUG);
  assign is_idcode = (ir_q == INSTR_IDCODE);

  always_comb begin
    ir_d         = ir_q;
    ir_shift_d   = ir_shift_q;
    idcode_sr_d  = idcode_sr_q;
    bypass_d     = bypass_q;
    tdo_d        = tdo_q;
    capture_dr_d = 1'b0;
    shift_dr_d   = 1'b0;
    update_dr_d  = 1'b0;
    tdi_o_d      = tdi_s2_q;

    if (tck_rise) begin
      unique case (state_q)
        CAP_IR: ir_shift_d = IR_CAPTURE;
        SH_IR:  ir_shift_d = {tdi_s2_q, ir_shift_q[IR_LENGTH-1:1]};
        UPD_IR: ir_d = ir_shift_q;
        CAP_DR: begin
          if (is_debug)       capture_dr_d = 1'b1;
          else if (is_idcode) idcode_sr_d  = IDCODE_VALUE;
          else                bypass_d     = 1'b0;
        end
        SH_DR: begin
          if (is_debug)       shift_dr_d  = 1'b1;
          else if (is_idcode) idcode_sr_d = {tdi_s2_q, idcode_sr_q[31:1]};
          else                bypass_d    = tdi_s2_q;
        end
        UPD_DR: update_dr_d = is_debug;
        default: ;
      endcase
    end

    // Holding IDCODE for the whole TLR stay is equivalent to loading it on entry.
    if (state_d == TLR) begin
      ir_d = INSTR_IDCODE;
    end

    if (tck_fall) begin
      unique case (state_q)
        SH_IR:   tdo_d = ir_shift_q[0];
        SH_DR:   tdo_d = is_debug ? debug_tdo_i : (is_idcode ? idcode_sr_q[0] : bypass_q);
        default: tdo_d = 1'b0;
      endcase
    end

    debug_select_d = (ir_d == INSTR_DEBUG);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ir_q           <= INSTR_IDCODE;
      ir_shift_q     <= '0;
      idcode_sr_q    <= '0;
      bypass_q       <= 1'b0;
      tdo_q          <= 1'b0;
      debug_select_q <= 1'b0;
      capture_dr_q   <= 1'b0;
      shift_dr_q     <= 1'b0;
      update_dr_q    <= 1'b0;
      tdi_o_q        <= 1'b0;
    end else begin
      ir_q           <= ir_d;
      ir_shift_q     <= ir_shift_d;
      idcode_sr_q    <= idcode_sr_d;
      bypass_q       <= bypass_d;
      tdo_q          <= tdo_d;
      debug_select_q <= debug_select_d;
      capture_dr_q   <= capture_dr_d;
      shift_dr_q     <= shift_dr_d;
      update_dr_q    <= update_dr_d;
      tdi_o_q        <= tdi_o_d;
    end
  end

  assign tdo_pad_o      = tdo_q;
  assign debug_select_o = debug_select_q;
  assign capture_dr_o   = capture_dr_q;
  assign shift_dr_o     = shift_dr_q;
  assign update_dr_o    = update_dr_q;
  assign tdi_o          = tdi_o_q;

endmodule

// File: doc/jtag_tap_sampled.md
# jtag_tap_sampled

JTAG TAP responder clocked entirely from the system clock. It oversamples the pad-level TCK/TMS/TDI, runs the IEEE 1149.1 16-state TAP controller, and implements the IR, IDCODE and BYPASS registers. It decodes a DEBUG instruction and exposes single-cycle capture/shift/update strobes to the debug unit. It sits between the orpsoc_top JTAG pads and the debug interface, as the target end of the jtag_vpi driver.

## Interface
- IDCODE_VALUE, 32'h14951185, value captured into the IDCODE DR (bit 0 must be 1).
- IR_LENGTH, 4, instruction register width.
- Instruction encodings are fixed: EXTEST 4'h0, SAMPLE_PRELOAD 4'h1, IDCODE 4'h2, DEBUG 4'h8, BYPASS 4'hF. Any other code behaves as BYPASS.
- wb_clk_i  in  1  system clock; all logic is on its rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- tck_pad_i  in  1  JTAG TCK, asynchronous to wb_clk_i.
- tms_pad_i  in  1  JTAG TMS, asynchronous.
- tdi_pad_i  in  1  JTAG TDI, asynchronous.
- tdo_pad_o  out  1  JTAG TDO, registered.
- debug_tdo_i  in  1  serial data from the debug unit, used as TDO source under DEBUG.
- debug_select_o  out  1  high while the active IR equals DEBUG.
- capture_dr_o  out  1  one-cycle strobe.
- shift_dr_o  out  1  one-cycle strobe.
- update_dr_o  out  1  one-cycle strobe.
- tdi_o  out  1  synchronized TDI, valid when shift_dr_o is high.

## Operation
- **Input synchronization:** TCK, TMS and TDI each pass through 2-FF synchronizers. A third TCK register provides edge detection.
  - rise = sync_tck & ~tck_d
  - fall = ~sync_tck & tck_d
- **TAP FSM:** 16 standard states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR. The FSM advances only on rise cycles, using sync TMS.
  - TLR: TMS 0 -> RTI, else stay.
  - RTI / UpdDR / UpdIR: TMS 1 -> SelDR, else RTI.
  - SelDR: TMS 1 -> SelIR, else CapDR.
  - SelIR: TMS 1 -> TLR, else CapIR.
  - Cap*: TMS 1 -> Ex1*, else Sh*.
  - Sh*: TMS 1 -> Ex1*, else stay.
  - Ex1*: TMS 1 -> Upd*, else Pause*.
  - Pause*: TMS 1 -> Ex2*, else stay.
  - Ex2*: TMS 1 -> Upd*, else Sh*.
- **IR:**
  - On rise in CapIR: the shift register loads 4'b0101.
  - On rise in ShIR: the register shifts right, with TDI entering the MSB.
  - On rise in UpdIR: the active IR loads from the shift register.
  - On entry to TLR: the active IR becomes IDCODE.
- **DR selection by active IR:**
  - IDCODE: 32-bit register. Loads IDCODE_VALUE on rise in CapDR, then shifts right with TDI entering the MSB.
  - BYPASS / EXTEST / SAMPLE_PRELOAD / unknown: 1-bit register. Loads 0 in CapDR and takes TDI in ShDR.
  - DEBUG: no local DR.
- **Debug strobes:** asserted for exactly one wb_clk_i cycle, on a rise cycle, only when IR == DEBUG.
  - capture_dr_o: current state CapDR.
  - shift_dr_o: current state ShDR.
  - update_dr_o: current state UpdDR.
- **TDO:** updated only on fall cycles.
  - ShIR: IR shift register bit 0.
  - ShDR: selected DR bit 0, or debug_tdo_i under DEBUG.
  - Any other state: TDO is 0.

## Timing
- Reset values: FSM = TLR, active IR = IDCODE, IR shift = 0, DR shifts = 0, synchronizers = 0.
- Outputs at reset: tdo_pad_o 0, debug_select_o 0, all strobes 0, tdi_o 0.
- Reset mid-scan aborts immediately; there is no pending update.
- Latency from a TCK pad edge to its detected rise/fall cycle is 3 wb_clk_i cycles.
- The FSM state, shift registers and strobes change in the rise cycle and are visible the following cycle.
- tdo_pad_o is visible 1 cycle after the fall cycle, i.e. 4 cycles after the pad falling edge.
- TCK high and low phases must each be ≥ 4 wb_clk_i cycles. TMS/TDI must be stable ≥ 4 cycles before the TCK rising edge.
- Narrower TCK pulses may be missed; the design must tolerate this without leaving the 16 legal states.
- TMS/TDI are sampled through the same 2-FF depth as TCK, so they are aligned with the detected edge.
- debug_select_o is registered and changes 1 cycle after the UpdIR rise cycle or after TLR entry.
- Five consecutive rises with TMS=1 reach TLR from any state.

## Test plan
- Reset: hold wb_rst_i 3 cycles -> FSM TLR, tdo_pad_o 0, debug_select_o 0, IR = 4'h2. Then apply TMS=1 for 8 TCKs -> remains TLR.
- IDCODE scan: TLR->RTI->SelDR->CapDR->ShDR, then 32 shifts -> TDO bits read LSB-first assemble 32'h14951185. The 33rd bit equals TDI shifted in at the first shift.
- IR load: shift 4'h8 through ShIR -> captured TDO bits 1,0,1,0 (4'b0101 LSB-first). After UpdIR, debug_select_o=1.
- Debug scan under DEBUG: CapDR then 3 ShDR with TDI 1,0,1 -> capture_dr_o 1 pulse, shift_dr_o 3 single-cycle pulses with tdi_o 1,0,1, update_dr_o 1 pulse. TDO mirrors debug_tdo_i.
- BYPASS: IR=4'hF, shift 8'hA5 -> TDO stream is 0 followed by A5 bits, i.e. a 1-bit delay.
- Reset mid-ShDR with IR=DEBUG -> next cycle FSM TLR, debug_select_o 0, no update_dr_o pulse. Then 5 TMS=1 TCKs -> stays TLR.
